// File: rtl/router_pkg.sv
// Shared constants and helpers for the router synchroniser.
package router_pkg;

  localparam int unsigned DEFAULT_SOFT_RST_CYC = 30;

  // Address width that can index n ports, never less than one bit.
  function automatic int unsigned calc_addr_w(input int unsigned n);
    int unsigned w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/router_sync_timer.sv
// Per-port stall timeout: pulses soft_reset for one cycle after SOFT_RST_CYC
// consecutive edges with valid data that is not being read.
module router_sync_timer #(
  parameter int unsigned SOFT_RST_CYC = 30
) (
  input  logic clock,
  input  logic resetn,
  input  logic vld,
  input  logic read_enb,
  output logic soft_reset
);

  localparam int unsigned CntW = $clog2(SOFT_RST_CYC);
  localparam logic [CntW-1:0] CntMax = CntW'(SOFT_RST_CYC - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            pulse_q, pulse_d;
  logic            stall;

  assign stall = vld & ~read_enb;

  always_comb begin
    cnt_d   = '0;
    pulse_d = 1'b0;
    if (stall) begin
      if (cnt_q == CntMax) begin
        pulse_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign soft_reset = pulse_q;

endmodule

// File: rtl/router_sync_param.sv
// Router synchroniser: latches the header destination, steers FIFO writes,
// reports the selected FIFO's full flag and runs per-port stall timeouts.
module router_sync_param
  import router_pkg::*;
#(
  parameter int unsigned NUM_PORTS    = 3,
  parameter int unsigned SOFT_RST_CYC = DEFAULT_SOFT_RST_CYC,
  localparam int unsigned ADDR_W      = calc_addr_w(NUM_PORTS)
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 detect_add,
  input  logic                 write_enb_reg,
  input  logic [ADDR_W-1:0]    data_in,
  input  logic [NUM_PORTS-1:0] read_enb,
  input  logic [NUM_PORTS-1:0] empty,
  input  logic [NUM_PORTS-1:0] full,
  output logic [NUM_PORTS-1:0] vld_out,
  output logic [NUM_PORTS-1:0] soft_reset,
  output logic [NUM_PORTS-1:0] write_enb,
  output logic                 fifo_full,
  output logic                 addr_err
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              addr_err_q, addr_err_d;

  always_comb begin
    addr_d     = addr_q;
    addr_err_d = addr_err_q;
    if (detect_add) begin
      addr_d     = data_in;
      addr_err_d = (32'(data_in) >= NUM_PORTS);
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      addr_q     <= '0;
      addr_err_q <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      addr_err_q <= addr_err_d;
    end
  end

  // Decode against the latched address only; an out-of-range address selects nothing.
  always_comb begin
    write_enb = '0;
    fifo_full = 1'b0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (!addr_err_q && (addr_q == ADDR_W'(i))) begin
        write_enb[i] = write_enb_reg;
        fifo_full    = full[i];
      end
    end
  end

  assign vld_out  = ~empty;
  assign addr_err = addr_err_q;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : gen_timer
    router_sync_timer #(
      .SOFT_RST_CYC(SOFT_RST_CYC)
    ) u_timer (
      .clock     (clock),
      .resetn    (resetn),
      .vld       (vld_out[g]),
      .read_enb  (read_enb[g]),
      .soft_reset(soft_reset[g])
    );
  end

endmodule

// File: tb/tb_router_sync_param.sv
// Directed bench for router_sync_param: default 3-port instance plus a
// 4-port, 8-cycle-timeout instance for the mid-count reset scenario.
module tb_router_sync_param;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Instance A: NUM_PORTS=3, SOFT_RST_CYC=30
  logic       a_resetn, a_detect_add, a_write_enb_reg;
  logic [1:0] a_data_in;
  logic [2:0] a_read_enb, a_empty, a_full;
  logic [2:0] a_vld_out, a_soft_reset, a_write_enb;
  logic       a_fifo_full, a_addr_err;

  // Instance B: NUM_PORTS=4, SOFT_RST_CYC=8
  logic       b_resetn, b_detect_add, b_write_enb_reg;
  logic [1:0] b_data_in;
  logic [3:0] b_read_enb, b_empty, b_full;
  logic [3:0] b_vld_out, b_soft_reset, b_write_enb;
  logic       b_fifo_full, b_addr_err;

  router_sync_param #(
    .NUM_PORTS   (3),
    .SOFT_RST_CYC(30)
  ) u_dut_a (
    .clock        (clock),
    .resetn       (a_resetn),
    .detect_add   (a_detect_add),
    .write_enb_reg(a_write_enb_reg),
    .data_in      (a_data_in),
    .read_enb     (a_read_enb),
    .empty        (a_empty),
    .full         (a_full),
    .vld_out      (a_vld_out),
    .soft_reset   (a_soft_reset),
    .write_enb    (a_write_enb),
    .fifo_full    (a_fifo_full),
    .addr_err     (a_addr_err)
  );

  router_sync_param #(
    .NUM_PORTS   (4),
    .SOFT_RST_CYC(8)
  ) u_dut_b (
    .clock        (clock),
    .resetn       (b_resetn),
    .detect_add   (b_detect_add),
    .write_enb_reg(b_write_enb_reg),
    .data_in      (b_data_in),
    .read_enb     (b_read_enb),
    .empty        (b_empty),
    .full         (b_full),
    .vld_out      (b_vld_out),
    .soft_reset   (b_soft_reset),
    .write_enb    (b_write_enb),
    .fifo_full    (b_fifo_full),
    .addr_err     (b_addr_err)
  );

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    a_resetn        = 1'b0;
    a_detect_add    = 1'($urandom);
    a_write_enb_reg = 1'b0;
    a_data_in       = 2'($urandom);
    a_read_enb      = 3'($urandom);
    a_empty         = 3'($urandom);
    a_full          = 3'($urandom);
    b_resetn        = 1'b0;
    b_detect_add    = 1'($urandom);
    b_write_enb_reg = 1'b0;
    b_data_in       = 2'($urandom);
    b_read_enb      = 4'($urandom);
    b_empty         = 4'($urandom);
    b_full          = 4'($urandom);
    step();
    total_cnt++;
    if (a_soft_reset !== 3'b000) $display("FAIL reset_soft_reset: got %b expected 000", a_soft_reset);
    else pass_cnt++;
    total_cnt++;
    if (a_addr_err !== 1'b0) $display("FAIL reset_addr_err: got %b expected 0", a_addr_err);
    else pass_cnt++;
    total_cnt++;
    if (a_write_enb !== 3'b000) $display("FAIL reset_write_enb: got %b expected 000", a_write_enb);
    else pass_cnt++;
    total_cnt++;
    if (a_vld_out !== ~a_empty) $display("FAIL reset_vld_out: got %b expected %b", a_vld_out, ~a_empty);
    else pass_cnt++;
    total_cnt++;
    if (b_soft_reset !== 4'b0000) $display("FAIL reset_b_soft_reset: got %b expected 0000", b_soft_reset);
    else pass_cnt++;
    a_resetn     = 1'b1;
    a_detect_add = 1'b0;
    a_read_enb   = 3'b000;
    a_empty      = 3'b111;
    a_full       = 3'b000;
    b_resetn     = 1'b1;
    b_detect_add = 1'b0;
    b_read_enb   = 4'b0000;
    b_empty      = 4'b1111;
    b_full       = 4'b0000;
    step();
  endtask

  task automatic test_addr_latch();
    a_detect_add    = 1'b1;
    a_data_in       = 2'd1;
    a_write_enb_reg = 1'b1;
    #1;
    // Same-cycle write still targets the old address 0.
    total_cnt++;
    if (a_write_enb !== 3'b001) $display("FAIL latch_same_cycle: got %b expected 001", a_write_enb);
    else pass_cnt++;
    step();
    a_detect_add = 1'b0;
    a_full       = 3'b010;
    #1;
    total_cnt++;
    if (a_write_enb !== 3'b010) $display("FAIL latch_write_enb: got %b expected 010", a_write_enb);
    else pass_cnt++;
    total_cnt++;
    if (a_fifo_full !== 1'b1) $display("FAIL latch_fifo_full: got %b expected 1", a_fifo_full);
    else pass_cnt++;
    a_full = 3'b101;
    #1;
    total_cnt++;
    if (a_fifo_full !== 1'b0) $display("FAIL latch_fifo_full_other: got %b expected 0", a_fifo_full);
    else pass_cnt++;
    a_write_enb_reg = 1'b0;
    #1;
    total_cnt++;
    if (a_write_enb !== 3'b000) $display("FAIL latch_no_req: got %b expected 000", a_write_enb);
    else pass_cnt++;
    a_full = 3'b000;
  endtask

  task automatic test_timeout();
    logic [2:0] exp;
    a_empty    = 3'b110;
    a_read_enb = 3'b000;
    #1;
    total_cnt++;
    if (a_vld_out !== 3'b001) $display("FAIL timeout_vld_out: got %b expected 001", a_vld_out);
    else pass_cnt++;
    for (int k = 1; k <= 61; k++) begin
      step();
      exp = (k == 30 || k == 60) ? 3'b001 : 3'b000;
      total_cnt++;
      if (a_soft_reset !== exp)
        $display("FAIL timeout_edge%0d: got %b expected %b", k, a_soft_reset, exp);
      else pass_cnt++;
    end
    a_empty = 3'b111;
    step();
  endtask

  task automatic test_timeout_abort();
    logic [2:0] exp;
    a_empty = 3'b110;
    for (int k = 1; k <= 60; k++) begin
      a_read_enb = (k == 29) ? 3'b001 : 3'b000;
      step();
      exp = (k == 59) ? 3'b001 : 3'b000;
      total_cnt++;
      if (a_soft_reset !== exp)
        $display("FAIL abort_edge%0d: got %b expected %b", k, a_soft_reset, exp);
      else pass_cnt++;
    end
    a_read_enb = 3'b000;
    a_empty    = 3'b111;
    step();
  endtask

  task automatic test_addr_err();
    a_detect_add = 1'b1;
    a_data_in    = 2'b11;
    step();
    a_detect_add    = 1'b0;
    a_write_enb_reg = 1'b1;
    a_full          = 3'b111;
    #1;
    total_cnt++;
    if (a_addr_err !== 1'b1) $display("FAIL err_addr_err: got %b expected 1", a_addr_err);
    else pass_cnt++;
    total_cnt++;
    if (a_write_enb !== 3'b000) $display("FAIL err_write_enb: got %b expected 000", a_write_enb);
    else pass_cnt++;
    total_cnt++;
    if (a_fifo_full !== 1'b0) $display("FAIL err_fifo_full: got %b expected 0", a_fifo_full);
    else pass_cnt++;
    a_detect_add = 1'b1;
    a_data_in    = 2'd2;
    step();
    a_detect_add = 1'b0;
    a_full       = 3'b100;
    #1;
    total_cnt++;
    if (a_addr_err !== 1'b0) $display("FAIL err_clear: got %b expected 0", a_addr_err);
    else pass_cnt++;
    total_cnt++;
    if (a_write_enb !== 3'b100) $display("FAIL err_port2_write_enb: got %b expected 100", a_write_enb);
    else pass_cnt++;
    total_cnt++;
    if (a_fifo_full !== 1'b1) $display("FAIL err_port2_fifo_full: got %b expected 1", a_fifo_full);
    else pass_cnt++;
    a_write_enb_reg = 1'b0;
    a_full          = 3'b000;
  endtask

  task automatic test_reset_mid_count();
    logic [3:0] exp;
    b_empty    = 4'b0000;
    b_read_enb = 4'b0000;
    for (int k = 1; k <= 14; k++) begin
      b_resetn = (k == 5) ? 1'b0 : 1'b1;
      step();
      exp = (k == 13) ? 4'b1111 : 4'b0000;
      total_cnt++;
      if (b_soft_reset !== exp)
        $display("FAIL midreset_edge%0d: got %b expected %b", k, b_soft_reset, exp);
      else pass_cnt++;
    end
    b_empty = 4'b1111;
    step();
  endtask

  initial begin
    test_reset();
    test_addr_latch();
    test_timeout();
    test_timeout_abort();
    test_addr_err();
    test_reset_mid_count();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
